// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier.
// Holds one registered result and the ZF/SF/OF condition-code register.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        set_cc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        illegal,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nx;
  logic [63:0] mcand, mplier, acc;
  logic [5:0]  cnt;
  logic        mul_cc;

  logic [63:0] sum, diff, alu_r, acc_step;
  logic [5:0]  shamt;
  logic        alu_of, alu_ill;
  logic        is_mul, accept, pop, mul_done;

  assign sum      = a + b;
  assign diff     = a - b;
  assign shamt    = b[5:0];
  assign is_mul   = (op == 4'd8);
  assign pop      = out_valid && out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_step = mplier[0] ? acc + mcand : acc;
  assign mul_done = (state == BUSY) && (cnt == 6'd63);

  // Single-cycle ALU result, overflow and illegal-op decode
  always_comb begin
    alu_r   = '0;
    alu_of  = 1'b0;
    alu_ill = 1'b0;
    unique case (1'b1)
      op == 4'd0: begin
        alu_r  = sum;
        alu_of = (a[63] == b[63]) && (sum[63] != a[63]);
      end
      op == 4'd1: begin
        alu_r  = diff;
        alu_of = (a[63] != b[63]) && (diff[63] != a[63]);
      end
      op == 4'd2: alu_r = a & b;
      op == 4'd3: alu_r = a ^ b;
      op == 4'd4: alu_r = a | b;
      op == 4'd5: alu_r = a << shamt;
      op == 4'd6: alu_r = a >> shamt;
      op == 4'd7: alu_r = $signed(a) >>> shamt;
      op == 4'd8: alu_r = '0;
      default:    alu_ill = 1'b1;
    endcase
  end

  // Next state and handshake: accept only when the result slot frees
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        if (accept && is_mul)
          state_nx = BUSY;
      end
      BUSY: begin
        if (cnt == 6'd63)
          state_nx = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Multiplier datapath: one shift-add step per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      mul_cc <= 1'b0;
    end else if (state == IDLE) begin
      if (accept && is_mul) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
        mul_cc <= set_cc;
      end
    end else begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 6'd1;
    end
  end

  // Result register, valid flag and condition codes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
      zf        <= 1'b1;
      sf        <= 1'b0;
      of        <= 1'b0;
    end else begin
      if (pop)
        out_valid <= 1'b0;
      if (mul_done) begin
        result    <= acc_step;
        illegal   <= 1'b0;
        out_valid <= 1'b1;
        if (mul_cc) begin
          zf <= (acc_step == 64'd0);
          sf <= acc_step[63];
          of <= 1'b0;
        end
      end else if (state == IDLE && accept && !is_mul) begin
        result    <= alu_r;
        illegal   <= alu_ill;
        out_valid <= 1'b1;
        if (set_cc && !alu_ill) begin
          zf <= (alu_r == 64'd0);
          sf <= alu_r[63];
          of <= alu_of;
        end
      end
    end
  end

endmodule
